// File: rtl/md5_iter_core_if.sv
// md5_iter_core_if
//   Job and result channels of the folded MD5 engine.
//   Input channel : in_valid/in_ready carry one job (in_block, in_chain, in_target).
//   Output channel: out_valid/out_ready carry one result (out_digest, out_match).
//   Handshake rule for both channels: a transfer happens on a rising clock edge
//   where valid and ready are both high; the sender holds valid and its payload
//   unchanged until that edge, and ready never depends combinationally on valid.
//   Word packing of 128-bit fields: word 0 (A) = [31:0] ... word 3 (D) = [127:96].
//   Modports: slave = the core, master = the job producer / digest consumer.
interface md5_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic [127:0] in_chain;
    logic [127:0] in_target;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_digest;
    logic         out_match;

    modport slave (
        input  in_valid, in_block, in_chain, in_target, out_ready,
        output in_ready, out_valid, out_digest, out_match
    );

    modport master (
        output in_valid, in_block, in_chain, in_target, out_ready,
        input  in_ready, out_valid, out_digest, out_match
    );
endinterface

// File: rtl/md5_iter_core.sv
// md5_iter_core
//   Folded MD5 compression: one 512-bit block plus a 128-bit chaining value is
//   accepted, the 64 steps run STEPS_PER_CYCLE per clock on one state register,
//   and the digest (optionally fed forward) plus a partial target compare is
//   returned.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   core_if      slave side of md5_iter_core_if (job in, digest out)
//   dbg_state_o  FSM state: 0 = IDLE, 1 = RUN, 2 = DONE
module md5_iter_core #(
    parameter int STEPS_PER_CYCLE = 1,
    parameter int FEED_FORWARD    = 1,
    parameter int CMP_WORDS       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    md5_iter_core_if.slave       core_if,
    output logic [1:0]           dbg_state_o
);
    generate
        if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
              STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : g_bad_steps
            $error("md5_iter_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
        if (CMP_WORDS < 0 || CMP_WORDS > 4) begin : g_bad_cmp
            $error("md5_iter_core: CMP_WORDS must be 0..4");
        end
    endgenerate

    localparam logic [6:0] STEPS7 = 7'(STEPS_PER_CYCLE);
    localparam logic [5:0] STEPS6 = 6'(STEPS_PER_CYCLE);

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a,
        32'ha8304613, 32'hfd469501, 32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821, 32'hf61e2562, 32'hc040b340,
        32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8,
        32'h676f02d9, 32'h8d2a4c8a, 32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70, 32'h289b7ec6, 32'heaa127fa,
        32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92,
        32'hffeff47d, 32'h85845dd1, 32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts indexed by {round, step mod 4}.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    // One MD5 step on packed state {D, C, B, A}.
    function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [5:0] i,
                                              input logic [511:0] m);
        logic [31:0] a, b, c, d, f, x, t;
        logic [3:0]  g;
        logic [4:0]  s;
        a = st[31:0];
        b = st[63:32];
        c = st[95:64];
        d = st[127:96];
        // Message index formulas only depend on i mod 16, so 4-bit arithmetic wraps correctly.
        case (i[5:4])
            2'd0:    begin f = (b & c) | (~b & d); g = i[3:0];                 end
            2'd1:    begin f = (d & b) | (~d & c); g = i[3:0] * 4'd5 + 4'd1;   end
            2'd2:    begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5;   end
            default: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7;          end
        endcase
        s = S_TAB[{i[5:4], i[1:0]}];
        x = a + f + K_TAB[i] + m[{g, 5'd0} +: 32];
        // s is never zero, so the right shift by 32-s stays in range.
        t = (x << s) | (x >> (6'd32 - {1'b0, s}));
        md5_step = {c, b, b + t, d};
    endfunction

    state_t         state_q, state_d;
    logic [5:0]     cnt_q;
    logic [511:0]   blk_q;
    logic [127:0]   st_q;
    logic [127:0]   chain_q;
    logic [127:0]   tgt_q;
    logic [127:0]   dig_q;
    logic           match_q;
    logic [127:0]   step_out;
    logic [127:0]   dig_next;
    logic           match_next;
    logic           last_step;

    assign last_step = (state_q == ST_RUN) && (({1'b0, cnt_q} + STEPS7) == 7'd64);

    // Chain of STEPS_PER_CYCLE combinational steps starting at cnt_q.
    always_comb begin
        step_out = st_q;
        for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
            step_out = md5_step(step_out, cnt_q + 6'(j), blk_q);
        end
    end

    always_comb begin
        dig_next = '0;
        for (int w = 0; w < 4; w++) begin
            if (FEED_FORWARD != 0) dig_next[32*w +: 32] = step_out[32*w +: 32] + chain_q[32*w +: 32];
            else                   dig_next[32*w +: 32] = step_out[32*w +: 32];
        end
        match_next = (CMP_WORDS != 0);
        for (int w = 0; w < 4; w++) begin
            if (w < CMP_WORDS && dig_next[32*w +: 32] != tgt_q[32*w +: 32]) match_next = 1'b0;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (core_if.in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_step)         state_d = ST_DONE;
            ST_DONE: if (core_if.out_ready) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        core_if.in_ready   = (state_q == ST_IDLE);
        core_if.out_valid  = (state_q == ST_DONE);
        core_if.out_digest = dig_q;
        core_if.out_match  = match_q;
        dbg_state_o        = state_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            blk_q   <= '0;
            st_q    <= '0;
            chain_q <= '0;
            tgt_q   <= '0;
            dig_q   <= '0;
            match_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && core_if.in_valid) begin
                blk_q   <= core_if.in_block;
                st_q    <= core_if.in_chain;
                chain_q <= core_if.in_chain;
                tgt_q   <= core_if.in_target;
                cnt_q   <= '0;
            end
            if (state_q == ST_RUN) begin
                st_q  <= step_out;
                cnt_q <= cnt_q + STEPS6;
            end
            // Results only move on the RUN->DONE edge so they hold through backpressure.
            if (last_step) begin
                dig_q   <= dig_next;
                match_q <= match_next;
            end
        end
    end
endmodule

// File: doc/md5_iter_core.md
# md5_iter_core

Folded, parametrised MD5 compression engine. Accepts one 512-bit message block plus a 128-bit chaining value over a valid/ready handshake. Runs all 64 MD5 steps, STEPS_PER_CYCLE at a time, on one set of state registers, then returns the digest. Replaces long unrolled per-step pipelines where area matters. Adds an on-core partial target compare for the bruteforce datapath.

## Interface
- STEPS_PER_CYCLE, 1: MD5 steps evaluated combinationally per clock; legal values 1, 2, 4, 8, 16; other values are a synthesis error.
- FEED_FORWARD, 1: 1 = output state + chaining value (standard digest); 0 = output raw post-step-63 state.
- CMP_WORDS, 4: number of digest words (from word 0 = A upward) compared with in_target; 0 disables compare.
- clk  in  1  clock, all registers on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  block/chain/target valid.
- in_ready  out  1  core can accept a job.
- in_block  in  512  M[i] = in_block[32i+31:32i], i = 0..15.
- in_chain  in  128  A = [31:0], B = [63:32], C = [95:64], D = [127:96].
- in_target  in  128  same word packing as in_chain.
- out_valid  out  1  digest valid.
- out_ready  in  1  consumer accepts digest.
- out_digest  out  128  same word packing as in_chain.
- out_match  out  1  compared words all equal; qualified by out_valid.

## Operation
- States: IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE, in_valid = 1: register block, chain (working copy and saved copy) and target; step counter = 0; go to RUN. in_valid = 0: stay.
- RUN: each cycle apply steps i = cnt .. cnt+S-1 in order. Per step:
  - F = (B&C)|(~B&D) for i<16; (D&B)|(~D&C) for i<32; B^C^D for i<48; C^(B|~D) otherwise.
  - Message index g = i, (5i+1) mod 16, (3i+5) mod 16, (7i) mod 16 for rounds 0–3.
  - B' = B + rotl(A + F + K[i] + M[g], s[i]); A' = D, D' = C, C' = B. All sums are mod 2^32.
  - K[i] is the standard constant table. s[i] is the standard rotate table; neither is ever zero.
  - cnt += S.
- When cnt + S == 64:
  - Register out_digest = state + saved chain per word (FEED_FORWARD = 1) or the state alone (FEED_FORWARD = 0).
  - Register out_match = AND over words 0..CMP_WORDS-1 of (digest word == target word); out_match = 0 when CMP_WORDS = 0.
  - Go to DONE.
- DONE: hold out_digest and out_match stable. Return to IDLE on out_valid & out_ready. in_valid is ignored in DONE.
- in_valid while in_ready = 0 is ignored; the producer must hold the job until accepted.
- rst_n low, any state, including mid-RUN:
  - Immediately go to IDLE, cnt = 0, out_valid = 0, out_match = 0, out_digest = 0.
  - The in-flight job is discarded, not resumed.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_digest = 0, out_match = 0.
- Accept edge E0 (in_valid & in_ready). RUN occupies edges E1..EN, N = 64/S. out_valid is high from just after EN.
  - S = 1: 64-edge latency from accept to out_valid.
  - S = 16: 4-edge latency.
- Job issue interval when out_ready is held high: N + 2 cycles (accept, N RUN, one DONE).
- in_ready drops on the edge after accept. It returns the edge after the output handshake.
- out_digest and out_match change only on the RUN→DONE edge and on reset.

## Test plan
- Empty string: M0 = 0x00000080, M1..M15 = 0, chain = IV (A=67452301, B=efcdab89, C=98badcfe, D=10325476).
  - Required out_digest words A..D = d98c1dd4, 04b2008f, 980980e9, 7e42f8ec.
  - out_valid rises 64/S edges after accept, for each legal S.
- "abc": M0 = 0x80636261, M14 = 0x00000018, others 0, chain = IV.
  - Required A..D = 98500190, b04fd23c, 7d3f96d6, 727fe128.
  - With target equal to that digest and CMP_WORDS = 4: out_match = 1.
  - Flip target D bit 0: out_match = 1 only when CMP_WORDS ≤ 3.
- FEED_FORWARD = 0 with the empty-string block: required out_digest word A = 0x7246fad3.
- Backpressure: out_ready low for 10 cycles in DONE.
  - out_digest and out_match stay stable; in_ready stays 0; a new in_valid is not accepted.
  - Release out_ready: in_ready = 1 on the next cycle.
- Reset mid-RUN: assert rst_n low at step 30.
  - out_valid = 0 and in_ready = 1 immediately.
  - After release, a fresh "abc" job produces the correct digest.
- Back-to-back: ten random blocks with in_valid and out_ready held high.
  - Every digest matches the reference model.
  - Accept-to-accept spacing is exactly 64/S + 2 cycles.
